nios_pio_in_irq: RTL and testbench



---
 rtl/nios_pio_in_irq_if.sv | 11 +
 rtl/nios_pio_in_irq.sv | 89 ++++++++
 tb/tb_nios_pio_in_irq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nios_pio_in_irq_if.sv
// nios_pio_in_irq_if: Avalon-MM slave bus bundle for the input PIO
interface nios_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_pio_in_irq.sv
// nios_pio_in_irq: Avalon-MM input PIO with synchroniser, debounce, edge capture and irq
module nios_pio_in_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    nios_pio_in_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port
);
    localparam int ARM = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int AW  = $clog2(ARM + 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] sync, deb, prev_q, mask_q, mask_d, ec_q, ec_d, edge_sel, clr;
    logic [AW-1:0]    arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr, armed;

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0]         deb_q, deb_d;
            // a new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
            always_comb begin
                deb_d = deb_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (sync[i] != deb_q[i]) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync[i];
                        else cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end
            assign deb = deb_q;
        end else begin : g_nodeb
            assign deb = sync;
        end
    endgenerate

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
        wr         = bus.chipselect & ~bus.write_n;
        armed      = arm_q == AW'(ARM);
        arm_d      = armed ? arm_q : arm_q + 1'b1;
        edge_sel   = EDGE_TYPE == 0 ? deb & ~prev_q : EDGE_TYPE == 1 ? ~deb & prev_q : deb ^ prev_q;
        clr        = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
        ec_d       = (ec_q & ~clr) | (armed ? edge_sel : '0);
        mask_d     = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
        readdata_d = bus.address == 2'd0 ? 32'(deb) :
                     bus.address == 2'd2 ? 32'(mask_q) :
                     bus.address == 2'd3 ? 32'(ec_q) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            ec_q       <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= deb;
            mask_q     <= mask_d;
            ec_q       <= ec_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = IRQ_MODE == 1 ? |(ec_q & mask_q) : |(deb & mask_q);
endmodule

// File: tb/tb_nios_pio_in_irq.sv
// tb_nios_pio_in_irq: vector table, randomized model check and corner sequences for the input PIO
module tb_nios_pio_in_irq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  a_addr, b_addr;
    logic        a_cs, b_cs, a_wn, b_wn;
    logic [31:0] a_wd, b_wd;
    logic [7:0]  a_in, b_in;

    nios_pio_in_irq_if if_a ();
    nios_pio_in_irq_if if_b ();
    assign if_a.address = a_addr;
    assign if_a.chipselect = a_cs;
    assign if_a.write_n = a_wn;
    assign if_a.writedata = a_wd;
    assign if_b.address = b_addr;
    assign if_b.chipselect = b_cs;
    assign if_b.write_n = b_wn;
    assign if_b.writedata = b_wd;

    nios_pio_in_irq dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a), .in_port(a_in));
    nios_pio_in_irq #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IRQ_MODE(0))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b), .in_port(b_in));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drives one write, returns #1 after its clock edge with the bus idle again
    task automatic wr(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        if (sel) begin b_cs = 1; b_wn = 0; b_addr = addr; b_wd = data; end
        else     begin a_cs = 1; a_wn = 0; a_addr = addr; a_wd = data; end
        @(posedge clk);
        #1;
        if (sel) begin b_cs = 0; b_wn = 1; end
        else     begin a_cs = 0; a_wn = 1; end
    endtask

    typedef struct {
        logic        cs, wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  in;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    function automatic vec_t mk(logic cs, logic wn, logic [1:0] addr, logic [31:0] wd,
                                logic [7:0] in, logic [31:0] rd, logic irq);
        vec_t v;
        v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.in = in; v.rd = rd; v.irq = irq;
        return v;
    endfunction

    vec_t tv[25];
    logic [7:0] hist[0:1023];

    initial begin
        logic [7:0]  m_mask, m_ec, d_old, p_old, ed;
        logic [31:0] e_rd;
        logic        w;
        int          n;
        tv[0]  = mk(0, 1, 0, 0, 8'hA5, 0, 0);
        tv[1]  = mk(0, 1, 0, 0, 8'hA5, 0, 0);
        tv[2]  = mk(0, 1, 0, 0, 8'hA5, 32'hA5, 0);
        tv[3]  = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[4]  = mk(1, 0, 2, 32'hFFFF_FF01, 8'hA5, 0, 0);
        tv[5]  = mk(0, 1, 2, 0, 8'hA5, 32'h01, 0);
        tv[6]  = mk(0, 1, 3, 0, 8'hA4, 0, 0);
        tv[7]  = mk(0, 1, 3, 0, 8'hA4, 0, 0);
        tv[8]  = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[9]  = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[10] = mk(0, 1, 3, 0, 8'hA5, 0, 1);
        tv[11] = mk(0, 1, 3, 0, 8'hA5, 32'h01, 1);
        tv[12] = mk(1, 0, 3, 32'h01, 8'hA5, 32'h01, 0);
        tv[13] = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[14] = mk(0, 1, 3, 0, 8'hA4, 0, 0);
        tv[15] = mk(0, 1, 3, 0, 8'hA4, 0, 0);
        tv[16] = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[17] = mk(0, 1, 3, 0, 8'hA5, 0, 0);
        tv[18] = mk(1, 0, 3, 32'h01, 8'hA5, 0, 1);
        tv[19] = mk(0, 1, 3, 0, 8'hA5, 32'h01, 1);
        tv[20] = mk(1, 0, 0, 32'hFF, 8'hA5, 32'hA5, 1);
        tv[21] = mk(1, 0, 1, 32'hFF, 8'hA5, 0, 1);
        tv[22] = mk(0, 1, 0, 0, 8'hA5, 32'hA5, 1);
        tv[23] = mk(1, 0, 2, 0, 8'hA5, 32'h01, 0);
        tv[24] = mk(0, 1, 2, 0, 8'hA5, 0, 0);

        a_addr = 0; a_cs = 0; a_wn = 1; a_wd = 0; a_in = 8'hA5;
        b_addr = 0; b_cs = 0; b_wn = 1; b_wd = 0; b_in = 0;
        repeat (3) @(negedge clk);
        chk("reset readdata", if_a.readdata, 0);
        chk("reset irq", {31'd0, if_a.irq}, 0);
        reset_n = 1;

        for (int i = 0; i < 25; i++) begin
            a_cs = tv[i].cs; a_wn = tv[i].wn; a_addr = tv[i].addr; a_wd = tv[i].wd; a_in = tv[i].in;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d readdata", i), if_a.readdata, tv[i].rd);
            chk($sformatf("vec%0d irq", i), {31'd0, if_a.irq}, {31'd0, tv[i].irq});
            @(negedge clk);
        end

        a_cs = 0; a_wn = 1; reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        n = 0; m_mask = 0; m_ec = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) a_in = 8'($urandom);
            a_cs = 1'($urandom_range(0, 1));
            a_wn = 1'($urandom_range(0, 1));
            a_addr = 2'($urandom_range(0, 3));
            a_wd = $urandom;
            n++;
            hist[n] = a_in;
            @(posedge clk);
            // an input sample appears on data two edges later; edges are armed from edge 4 on
            d_old = n >= 3 ? hist[n-2] : 8'h00;
            p_old = n >= 4 ? hist[n-3] : 8'h00;
            ed = n >= 4 ? d_old & ~p_old : 8'h00;
            w = a_cs & ~a_wn;
            e_rd = a_addr == 0 ? 32'(d_old) : a_addr == 2 ? 32'(m_mask) : a_addr == 3 ? 32'(m_ec) : 0;
            if (w && a_addr == 2) m_mask = a_wd[7:0];
            m_ec = (m_ec & ~((w && a_addr == 3) ? a_wd[7:0] : 8'h00)) | ed;
            #1;
            chk($sformatf("rand%0d readdata", c), if_a.readdata, e_rd);
            chk($sformatf("rand%0d irq", c), {31'd0, if_a.irq}, {31'd0, |(m_ec & m_mask)});
            @(negedge clk);
        end
        a_cs = 0; a_wn = 1;

        b_addr = 0; b_in = 8'h04;
        repeat (3) @(negedge clk);
        b_in = 0;
        repeat (12) @(negedge clk);
        chk("glitch data", if_b.readdata, 0);
        b_addr = 3;
        @(negedge clk);
        chk("glitch edgecapture", if_b.readdata, 0);
        b_addr = 0; b_in = 8'h04;
        repeat (12) @(negedge clk);
        chk("debounced data", if_b.readdata, 32'h04);
        b_addr = 3;
        @(negedge clk);
        chk("debounced edgecapture", if_b.readdata, 32'h04);
        wr(1, 3, 32'h04);
        @(negedge clk);

        wr(1, 2, 32'h80);
        chk("level low input", {31'd0, if_b.irq}, 0);
        @(negedge clk);
        b_in = 8'h84;
        repeat (10) @(negedge clk);
        chk("level high input", {31'd0, if_b.irq}, 1);
        wr(1, 2, 32'h00);
        chk("level mask off", {31'd0, if_b.irq}, 0);
        @(negedge clk);
        wr(1, 2, 32'h80);
        chk("level mask on", {31'd0, if_b.irq}, 1);
        @(negedge clk);
        b_in = 8'h04;
        repeat (10) @(negedge clk);
        chk("level input dropped", {31'd0, if_b.irq}, 0);

        wr(0, 2, 32'hFF);
        @(negedge clk);
        a_in = 8'h00;
        repeat (4) @(negedge clk);
        a_in = 8'hFF;
        repeat (4) @(negedge clk);
        a_addr = 3;
        @(negedge clk);
        chk("full edgecapture", if_a.readdata, 32'hFF);
        chk("full irq", {31'd0, if_a.irq}, 1);
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        chk("async reset readdata", if_a.readdata, 0);
        chk("async reset irq", {31'd0, if_a.irq}, 0);
        reset_n = 1;
        repeat (6) @(negedge clk);
        chk("armed after reset", if_a.readdata, 0);
        chk("armed after reset irq", {31'd0, if_a.irq}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
